// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: the 2-bit shift-mode encoding.
package pipelined_barrel_shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One registered log-stage of the barrel shifter: shifts by STEP when the matching
// shamt bit is set, selects the fill bits per mode, and holds everything while stalled.
module shift_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH),
  localparam int BIT   = $clog2(STEP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  shift_op_e        in_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output shift_op_e        out_op
);

  logic [WIDTH-1:0] shifted;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shifted = in_data;
    if (in_shamt[BIT]) begin
      unique case (in_op)
        SHIFT_LSL: shifted = in_data << STEP;
        SHIFT_LSR: shifted = in_data >> STEP;
        SHIFT_ASR: shifted = {{STEP{in_data[WIDTH-1]}}, in_data[WIDTH-1:STEP]};
        SHIFT_ROR: shifted = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
        default:   shifted = in_data;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every stage
  // samples its predecessor's pre-edge value regardless of evaluation order.
  // NOTE: data registers are reset too, because the last stage drives out_data,
  // which must read zero during reset; earlier stages just share the same code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shamt <= '0;
      out_op    <= SHIFT_LSL;
    end else if (advance) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_shamt <= in_shamt;
      out_op    <= in_op;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW registered log-stages, one beat per cycle, and the
// whole pipe freezes while the output beat is held back by out_ready.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Index k is the input of stage k; index SHW is the output register of the last stage.
  logic             valid_q [SHW+1];
  logic [WIDTH-1:0] data_q  [SHW+1];
  logic [SHW-1:0]   shamt_q [SHW+1];
  shift_op_e        op_q    [SHW+1];

  // Stalling is decided purely by the output handshake, so in_valid never reaches in_ready.
  assign in_ready = !(out_valid && !out_ready);

  assign valid_q[0] = in_valid;
  assign data_q[0]  = in_data;
  assign shamt_q[0] = in_shamt;
  assign op_q[0]    = shift_op_e'(in_op);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (in_ready),
      .in_valid  (valid_q[k]),
      .in_data   (data_q[k]),
      .in_shamt  (shamt_q[k]),
      .in_op     (op_q[k]),
      .out_valid (valid_q[k+1]),
      .out_data  (data_q[k+1]),
      .out_shamt (shamt_q[k+1]),
      .out_op    (op_q[k+1])
    );
  end

  assign out_valid = valid_q[SHW];
  assign out_data  = data_q[SHW];
  assign out_zero  = (data_q[SHW] == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and reference-model checks for pipelined_barrel_shifter at WIDTH=32.
module tb_pipelined_barrel_shifter;
  import pipelined_barrel_shifter_pkg::*;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0]   in_shamt = '0;
  logic [1:0]       in_op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q [$];

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                                             input logic [1:0] o);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return WIDTH'($signed(d) >>> s);
      default: return (s == 0) ? d : ((d >> s) | (d << (WIDTH - int'(s))));
    endcase
  endfunction

  // Output scoreboard: a transfer happens at the next rising edge whenever both are high here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", out_data, 32'hxxxx_xxxx);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e);
        check("out_zero", {31'b0, out_zero}, {31'b0, e == '0});
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that transfers the beat.
  task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s, input logic [1:0] o,
                      input logic [WIDTH-1:0] e);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = o;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) exp_q.push_back(e);
    else check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Exact latency: out_valid stays low for 3 more edges after the transfer edge and rises on the 4th.
  task automatic lat_check(input string tag);
    idle(3);
    check({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    idle(1);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    idle(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] stall_data;
    logic             stall_zero;

    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_data",  out_data,            32'd0);
    check("rst_out_zero",  {31'b0, out_zero},  32'd1);
    #20 rst_n = 1'b1;
    idle(1);

    // Single beats with exact latency: 0x8000_0001 by 4 in every mode.
    send(32'h8000_0001, 5'd4, 2'b00, 32'h0000_0010); lat_check("lsl4");
    send(32'h8000_0001, 5'd4, 2'b01, 32'h0800_0000); lat_check("lsr4");
    send(32'h8000_0001, 5'd4, 2'b10, 32'hF800_0000); lat_check("asr4");
    send(32'h8000_0001, 5'd4, 2'b11, 32'h1800_0000); lat_check("ror4");

    // Zero shift passes through; 31 is the widest shift; LSR to all-zero asserts out_zero.
    send(32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd31, 2'b01, 32'h0000_0001);
    send(32'hDEAD_BEEF, 5'd31, 2'b10, 32'hFFFF_FFFF);
    send(32'hDEAD_BEEF, 5'd31, 2'b00, 32'h8000_0000);
    send(32'hDEAD_BEEF, 5'd31, 2'b11, 32'hBD5B_7DDF);
    send(32'h0000_00F0, 5'd8,  2'b01, 32'h0000_0000);
    send(32'h7000_0000, 5'd3,  2'b10, 32'h0E00_0000);
    drain();

    // Back-to-back random beats against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] d;
      logic [SHW-1:0]   s;
      logic [1:0]       o;
      d = $urandom;
      s = SHW'($urandom_range(0, WIDTH - 1));
      o = 2'($urandom_range(0, 3));
      send(d, s, o, model(d, s, o));
    end
    drain();

    // Fill the pipe with out_ready low, hold three cycles, then release.
    out_ready = 1'b0;
    send(32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002);
    send(32'h8000_0000, 5'd2, 2'b10, 32'hE000_0000);
    send(32'h1234_5678, 5'd8, 2'b11, 32'h7812_3456);
    send(32'hFFFF_0000, 5'd16, 2'b01, 32'h0000_FFFF);
    send(32'h0000_0003, 5'd30, 2'b00, 32'hC000_0000);
    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    check("stall_in_ready",  {31'b0, in_ready},  32'd0);
    check("stall_head",      out_data,            32'h0000_0002);
    stall_data = out_data;
    stall_zero = out_zero;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("stall_hold_ready", {31'b0, in_ready},  32'd0);
      check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
      check("stall_hold_data",  out_data,            stall_data);
      check("stall_hold_zero",  {31'b0, out_zero},  {31'b0, stall_zero});
    end
    out_ready = 1'b1;
    send(32'h0000_0100, 5'd8, 2'b01, 32'h0000_0001);
    drain();

    // Reset with three beats in flight: all discarded, nothing stale afterwards.
    send(32'h1111_1111, 5'd1, 2'b00, 32'h2222_2222);
    send(32'h2222_2222, 5'd1, 2'b00, 32'h4444_4444);
    send(32'h4444_4444, 5'd1, 2'b00, 32'h8888_8888);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("mid_rst_out_data",  out_data,            32'd0);
    check("mid_rst_out_zero",  {31'b0, out_zero},  32'd1);
    #10 rst_n = 1'b1;
    idle(1);
    idle(8);
    check("post_rst_idle", {31'b0, out_valid}, 32'd0);
    send(32'h0000_000F, 5'd4, 2'b11, 32'hF000_0000);
    lat_check("post_rst");
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
